// File: rtl/traceback_ctrl_if.sv
// Handshake, output-word and survivor-SRAM signals of the Viterbi traceback controller.
// The controller uses the slave modport; the surrounding datapath uses master.
interface traceback_ctrl_if #(
    parameter int DEC_LEN = 16
);
    logic                dec_valid_i;
    logic                dec_ready_o;
    logic [63:0]         dec_data_i;
    logic [5:0]          best_state_i;
    logic                out_valid_o;
    logic                out_ready_i;
    logic [DEC_LEN-1:0]  out_data_o;
    logic                sram_wr_en_o;
    logic                sram_rd_en_o;
    logic [5:0]          sram_addr_o;
    logic [63:0]         sram_wdata_o;
    logic [63:0]         sram_rdata_i;
    logic                busy_o;

    modport slave (
        input  dec_valid_i, dec_data_i, best_state_i, out_ready_i, sram_rdata_i,
        output dec_ready_o, out_valid_o, out_data_o, sram_wr_en_o, sram_rd_en_o,
               sram_addr_o, sram_wdata_o, busy_o
    );

    modport master (
        output dec_valid_i, dec_data_i, best_state_i, out_ready_i, sram_rdata_i,
        input  dec_ready_o, out_valid_o, out_data_o, sram_wr_en_o, sram_rd_en_o,
               sram_addr_o, sram_wdata_o, busy_o
    );
endinterface

// File: rtl/traceback_ctrl.sv
// Viterbi traceback controller: fills a 64-entry survivor SRAM, traces back N steps, emits DEC_LEN bits.
// Define TBC_BEST_STATE_EN to start traceback from the newest best state instead of state 0.
module traceback_ctrl #(
    parameter int TB_LEN  = 32,
    parameter int DEC_LEN = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    traceback_ctrl_if.slave        bus
);
    localparam int N = TB_LEN + DEC_LEN;

    typedef enum logic [1:0] {
        S_FILL,
        S_TB,
        S_OUT
    } state_t;

    state_t              state_reg;
    logic [5:0]          wr_ptr_reg;
    logic [6:0]          cnt_reg;
    logic [6:0]          issue_reg;
    logic [6:0]          proc_reg;
    logic                rd_pend_reg;
    logic [5:0]          tst_reg;
    logic [DEC_LEN-1:0]  word_reg;
    logic                out_valid_reg;

    logic                dec_ready;
    logic                xfer;
    logic                rd_en;
    logic [5:0]          rd_addr;
    logic [5:0]          start_state;

    assign dec_ready = (state_reg == S_FILL) && (cnt_reg < 7'(N));
    // dec_ready stays high through reset, so the write strobe is masked explicitly
    assign xfer      = bus.dec_valid_i && dec_ready && !rst_i;
    assign rd_en     = (state_reg == S_TB) && (issue_reg < 7'(N));
    assign rd_addr   = wr_ptr_reg - 6'd1 - issue_reg[5:0];

`ifdef TBC_BEST_STATE_EN
    logic [5:0] last_best_reg;
    logic [5:0] best_next;

    assign best_next   = xfer ? bus.best_state_i : last_best_reg;
    assign start_state = best_next;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            last_best_reg <= 6'd0;
        end else begin
            last_best_reg <= best_next;
        end
    end
`else
    logic unused_best;

    assign unused_best = ^bus.best_state_i;
    assign start_state = 6'd0;
`endif

    assign bus.dec_ready_o  = dec_ready;
    assign bus.sram_wr_en_o = xfer;
    assign bus.sram_rd_en_o = rd_en;
    assign bus.sram_addr_o  = xfer ? wr_ptr_reg : (rd_en ? rd_addr : 6'd0);
    assign bus.sram_wdata_o = xfer ? bus.dec_data_i : 64'd0;
    assign bus.out_valid_o  = out_valid_reg;
    assign bus.out_data_o   = word_reg;
    assign bus.busy_o       = (state_reg != S_FILL);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg     <= S_FILL;
            wr_ptr_reg    <= 6'd0;
            cnt_reg       <= 7'd0;
            issue_reg     <= 7'd0;
            proc_reg      <= 7'd0;
            rd_pend_reg   <= 1'b0;
            tst_reg       <= 6'd0;
            word_reg      <= '0;
            out_valid_reg <= 1'b0;
        end else begin
            case (state_reg)
                S_FILL: begin
                    rd_pend_reg <= 1'b0;
                    if (xfer) begin
                        wr_ptr_reg <= wr_ptr_reg + 6'd1;
                        cnt_reg    <= cnt_reg + 7'd1;
                        if (cnt_reg == 7'(N - 1)) begin
                            state_reg <= S_TB;
                            issue_reg <= 7'd0;
                            proc_reg  <= 7'd0;
                            tst_reg   <= start_state;
                        end
                    end
                end
                S_TB: begin
                    // Reads stream out one per cycle; rd_pend_reg marks the cycle their data lands
                    rd_pend_reg <= rd_en;
                    if (rd_en) begin
                        issue_reg <= issue_reg + 7'd1;
                    end
                    if (rd_pend_reg) begin
                        // Only steps TB_LEN..N-1 map onto word bits; oldest step ends in bit 0
                        for (int b = 0; b < DEC_LEN; b++) begin
                            if (proc_reg == 7'(N - 1 - b)) begin
                                word_reg[b] <= tst_reg[5];
                            end
                        end
                        tst_reg  <= {tst_reg[4:0], bus.sram_rdata_i[tst_reg]};
                        proc_reg <= proc_reg + 7'd1;
                        if (proc_reg == 7'(N - 1)) begin
                            state_reg     <= S_OUT;
                            out_valid_reg <= 1'b1;
                        end
                    end
                end
                S_OUT: begin
                    if (bus.out_ready_i) begin
                        // The oldest DEC_LEN vectors are dropped logically; the SRAM keeps them
                        cnt_reg       <= cnt_reg - 7'(DEC_LEN);
                        state_reg     <= S_FILL;
                        out_valid_reg <= 1'b0;
                    end
                end
                default: begin
                    state_reg <= S_FILL;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_traceback_ctrl.sv
// Scoreboard bench for traceback_ctrl: random stimulus, software traceback model, decoupled monitor.
module tb_traceback_ctrl;
    localparam int TB_LEN  = 32;
    localparam int DEC_LEN = 16;
    localparam int N       = TB_LEN + DEC_LEN;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   checks = 0;
    int   passed = 0;
    logic hold = 1'b0;
    logic rdy_random = 1'b0;

    traceback_ctrl_if #(.DEC_LEN(DEC_LEN)) bus ();

    traceback_ctrl #(.TB_LEN(TB_LEN), .DEC_LEN(DEC_LEN)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Survivor SRAM: registered read, garbage whenever no read was issued
    logic [63:0] sram_mem [64];
    always @(posedge clk) begin
        if (bus.sram_wr_en_o) sram_mem[bus.sram_addr_o] <= bus.sram_wdata_o;
        if (bus.sram_rd_en_o) bus.sram_rdata_i <= sram_mem[bus.sram_addr_o];
        else                  bus.sram_rdata_i <= {$urandom, $urandom};
    end

    initial begin
        bus.out_ready_i = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.out_ready_i = hold ? 1'b0 : (rdy_random ? 1'($urandom_range(0, 1)) : 1'b1);
        end
    end

    // Reference model state
    logic [63:0]        mem_m [64];
    int                 wr_m = 0;
    int                 cnt_m = 0;
    logic [5:0]         best_m = 6'd0;
    logic [DEC_LEN-1:0] last_exp = '0;
    logic [DEC_LEN-1:0] exp_words [$];
    int                 exp_addrs [$];
    int                 exp_acc [$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    endtask

    function automatic logic [DEC_LEN-1:0] model_word();
        logic [DEC_LEN-1:0] w;
        logic [5:0]         s;
        logic [63:0]        v;
        w = '0;
`ifdef TBC_BEST_STATE_EN
        s = best_m;
`else
        s = 6'd0;
`endif
        for (int k = 0; k < N; k++) begin
            v = mem_m[(wr_m - 1 - k) & 63];
            if (k >= TB_LEN) w[N - 1 - k] = s[5];
            s = {s[4:0], v[s]};
        end
        return w;
    endfunction

    task automatic model_accept(input logic [63:0] d, input logic [5:0] b);
        mem_m[wr_m] = d;
        wr_m   = (wr_m + 1) & 63;
        cnt_m  = cnt_m + 1;
        best_m = b;
        if (cnt_m == N) begin
            last_exp = model_word();
            exp_words.push_back(last_exp);
            for (int k = 0; k < N; k++) exp_addrs.push_back((wr_m - 1 - k) & 63);
            exp_acc.push_back(cyc + 1);
            cnt_m = cnt_m - DEC_LEN;
        end
    endtask

    // Monitor: compares every read address and every new output word against the scoreboard
    logic prev_valid = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            prev_valid <= 1'b0;
        end else begin
            if (bus.sram_rd_en_o) begin
                check("strobe_excl", 64'(bus.sram_wr_en_o), 64'd0);
                if (exp_addrs.size() == 0) check("unexpected_read", 64'(bus.sram_addr_o), 64'hFFFF);
                else check("read_addr", 64'(bus.sram_addr_o), 64'(exp_addrs.pop_front()));
            end
            if (bus.out_valid_o && !prev_valid) begin
                if (exp_words.size() == 0) begin
                    check("unexpected_word", 64'(bus.out_data_o), 64'hDEAD_BEEF);
                end else begin
                    $display("word %h expected %h at cycle %0d", bus.out_data_o, exp_words[0], cyc);
                    check("out_data", 64'(bus.out_data_o), 64'(exp_words.pop_front()));
                    check("out_latency", 64'(cyc - exp_acc.pop_front()), 64'(N + 1));
                end
            end
            prev_valid <= bus.out_valid_o;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        bus.dec_valid_i = 1'b0;
        exp_words.delete();
        exp_addrs.delete();
        exp_acc.delete();
        wr_m = 0; cnt_m = 0; best_m = 6'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send_vec(input logic [63:0] d, input logic [5:0] b);
        bit done = 0;
        bus.dec_valid_i  = 1'b1;
        bus.dec_data_i   = d;
        bus.best_state_i = b;
        for (int t = 0; t < 300 && !done; t++) begin
            @(negedge clk);
            if (bus.dec_ready_o) begin
                model_accept(d, b);
                done = 1;
            end
            @(posedge clk);
            #1;
        end
        if (!done) begin
            checks++;
            $display("FAIL accept_timeout: vector not accepted within 300 cycles");
        end
        bus.dec_valid_i = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_words.size() != 0 || exp_addrs.size() != 0) && t < 600) begin
            @(posedge clk);
            t++;
        end
        #1;
        check("drain_words", 64'(exp_words.size()), 64'd0);
    endtask

    initial begin
        int n;
        int seen;
        rst = 1'b1;
        bus.dec_valid_i  = 1'b0;
        bus.dec_data_i   = 64'd0;
        bus.best_state_i = 6'd0;

        // Reset values during and after reset
        @(negedge clk);
        check("rst_out_valid", 64'(bus.out_valid_o), 64'd0);
        check("rst_strobes", {62'd0, bus.sram_wr_en_o, bus.sram_rd_en_o}, 64'd0);
        check("rst_addr_wdata", bus.sram_wdata_o | 64'(bus.sram_addr_o), 64'd0);
        do_reset();
        @(negedge clk);
        check("rst_dec_ready", 64'(bus.dec_ready_o), 64'd1);
        check("rst_busy", 64'(bus.busy_o), 64'd0);
        check("rst_out_data", 64'(bus.out_data_o), 64'd0);
        @(posedge clk); #1;

        // All-zero vectors
        for (int i = 0; i < N; i++) send_vec(64'd0, 6'd0);
        drain();

        // All-ones vectors from state 0
        do_reset();
        for (int i = 0; i < N; i++) send_vec({64{1'b1}}, 6'd0);
        check("ones_model", 64'(last_exp), 64'hFFFF);
        drain();

        // Sink stalls for 10 cycles in OUT, then 16 more vectors make the next word
        do_reset();
        hold = 1'b1;
        for (int i = 0; i < N; i++) send_vec({$urandom, $urandom}, 6'($urandom));
        n = 0;
        while (!bus.out_valid_o && n < 200) begin @(negedge clk); n++; end
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_valid", 64'(bus.out_valid_o), 64'd1);
            check("hold_data", 64'(bus.out_data_o), 64'(last_exp));
            check("hold_ready_strobes",
                  {61'd0, bus.dec_ready_o, bus.sram_wr_en_o, bus.sram_rd_en_o}, 64'd0);
        end
        hold = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < DEC_LEN; i++) send_vec({$urandom, $urandom}, 6'($urandom));
        drain();

        // Long random run with wrap-around and a random sink
        do_reset();
        rdy_random = 1'b1;
        for (int i = 0; i < 200; i++) begin
            repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
            send_vec({$urandom, $urandom}, 6'($urandom));
        end
        drain();
        rdy_random = 1'b0;

        // Reset in the middle of traceback at read k=20
        do_reset();
        for (int i = 0; i < N; i++) send_vec({$urandom, $urandom}, 6'($urandom));
        n = 0;
        for (int t = 0; t < 200 && n < 21; t++) begin
            @(negedge clk);
            if (bus.sram_rd_en_o) n++;
        end
        rst = 1'b1;
        exp_words.delete();
        exp_addrs.delete();
        exp_acc.delete();
        wr_m = 0; cnt_m = 0; best_m = 6'd0;
        @(negedge clk);
        check("abort_strobes", {62'd0, bus.sram_wr_en_o, bus.sram_rd_en_o}, 64'd0);
        check("abort_valid_busy", {62'd0, bus.out_valid_o, bus.busy_o}, 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (bus.out_valid_o) seen++;
        end
        check("abort_no_word", 64'(seen), 64'd0);
        check("abort_dec_ready", 64'(bus.dec_ready_o), 64'd1);
        @(posedge clk); #1;
        for (int i = 0; i < N; i++) send_vec({$urandom, $urandom}, 6'($urandom));
        drain();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule

// File: doc/traceback_ctrl.md
TRACEBACK_CTRL -- requirements
Module: traceback_ctrl

Interface
REQ-001 Parameter TB_LEN, default 32: traceback depth in trellis steps, not decoded.
REQ-002 Parameter DEC_LEN, default 16: decoded bits per output word; TB_LEN+DEC_LEN (=N) SHALL be <=64 and DEC_LEN >=1.
REQ-003 clk_i  input  1  clock; all state changes on rising edge.
REQ-004 rst_i  input  1  reset, asynchronous, active-high.
REQ-005 dec_valid_i  input  1  64-bit decision vector (one trellis step) offered.
REQ-006 dec_ready_o  output  1  controller accepts vector; transfer when dec_valid_i & dec_ready_o.
REQ-007 dec_data_i  input  64  decision bits, bit s = survivor bit of state s.
REQ-008 best_state_i  input  6  best path-metric state, sampled with each accepted vector.
REQ-009 out_valid_o  output  1  decoded word valid, held until accepted.
REQ-010 out_ready_i  input  1  sink accepts word when out_valid_o & out_ready_i.
REQ-011 out_data_o  output  DEC_LEN  decoded bits, bit 0 = oldest.
REQ-012 sram_wr_en_o / sram_rd_en_o  output  1 each  survivor SRAM write / read strobe, never both high.
REQ-013 sram_addr_o  output  6  SRAM address.
REQ-014 sram_wdata_o  output  64  SRAM write data.
REQ-015 sram_rdata_i  input  64  SRAM read data, valid only the cycle after a sram_rd_en_o cycle; undefined/Z otherwise and SHALL be ignored then.
REQ-016 busy_o  output  1  high in TB or OUT state.

Function
REQ-017 FSM states FILL, TB, OUT; wr_ptr (6-bit, wraps 63->0) and cnt (0..N) registers.
REQ-018 FILL: dec_ready_o = (cnt < N); on transfer, same cycle sram_wr_en_o=1, sram_addr_o=wr_ptr, sram_wdata_o=dec_data_i; at edge wr_ptr+1, cnt+1, last_best<=best_state_i.
REQ-019 FILL->TB at the edge where cnt becomes N.
REQ-020 TB: dec_ready_o=0; reads issued back-to-back, read k (k=0..N-1) at address (wr_ptr-1-k) mod 64, one per cycle, no gaps.
REQ-021 Trace state tst loaded at TB entry with start state (see Configuration); on data for read k: d = sram_rdata_i[tst]; if k >= TB_LEN, out_data_o bit (N-1-k) <= tst[5]; then tst <= {tst[4:0], d}.
REQ-022 TB->OUT at the edge processing read N-1; out_valid_o high exactly N+1 cycles after the edge accepting the N-th vector.
REQ-023 OUT: out_valid_o=1, out_data_o stable, no SRAM access; on out_ready_i: cnt <= cnt-DEC_LEN, wr_ptr unchanged, ->FILL.
REQ-024 Oldest DEC_LEN entries are discarded only logically; next block needs DEC_LEN new vectors.
REQ-025 dec_valid_i while dec_ready_o=0 SHALL be held off with no write and no state change.

Reset
REQ-026 On rst_i: state FILL, cnt=0, wr_ptr=0, tst=0, last_best=0, all outputs 0 except dec_ready_o=1 once rst_i releases (0 during reset permitted? no: dec_ready_o SHALL be 1 combinationally from cnt=0 state FILL).
REQ-027 Reset mid-TB/OUT aborts traceback; partial word discarded, no out_valid_o pulse, SRAM strobes low next cycle.

Configuration
REQ-028 Macro TBC_BEST_STATE_EN defined: traceback starts from last_best (best_state_i of newest vector).
REQ-029 Macro undefined: traceback starts from state 0; best_state_i ignored, last_best register absent.

Verification
REQ-030 Reset asserted -> all outputs 0, dec_ready_o=1, busy_o=0 after release.
REQ-031 48 all-zero vectors, best 0 -> out_data_o=16'h0000, out_valid_o 49 cycles after 48th accept, 48 consecutive reads at addrs 47..0.
REQ-032 48 all-ones vectors, start state 0 -> out_data_o=16'hFFFF.
REQ-033 out_ready_i low 10 cycles in OUT -> out_valid_o/out_data_o held, dec_ready_o=0, no SRAM strobes; after accept cnt=32, next word after 16 more vectors.
REQ-034 200 random vectors, random out_ready_i -> wr_ptr wraps, read addresses and all words match software traceback model (both macro settings).
REQ-035 rst_i pulsed at read k=20 -> next cycle strobes low, no word emitted, fresh 48-vector fill required.
